inquire_scan: RTL and testbench
===============================

// Module: inquire_scan
// PURPOSE
//  Query-mode controller, parametrised over item count. While query mode is requested (in && en),
//  steps an item index through NUM_ITEMS entries via next/prev pulses or optional auto-scan.
//  Drops out of query mode on request removal or user inactivity timeout.
//  Sits between debounced key/switch logic and the display/readout datapath.
// PARAMETERS
//  NUM_ITEMS  8     number of queryable items, >=2; IDX_W = max(1,$clog2(NUM_ITEMS))
//  TIMEOUT    1000  cycles without next/prev before forced exit; 0 = timeout disabled
//  AUTO_SCAN  0     1 = index auto-advances every DWELL cycles while active
//  DWELL      100   auto-scan dwell in cycles, >=1 (ignored when AUTO_SCAN=0)
// PORTS
//  clk         in   1      single clock, rising edge
//  rst_n       in   1      reset, asynchronous, active-low
//  in          in   1      query-mode request level
//  en          in   1      global enable level
//  next_p      in   1      one-cycle pulse: advance index
//  prev_p      in   1      one-cycle pulse: step index back
//  inquire     out  1      registered: 1 while in ACTIVE state
//  item_idx    out  IDX_W  registered current item index; 0 outside ACTIVE
//  item_strobe out  1      one-cycle pulse: item_idx newly valid (entry or any index change)
//  timed_out   out  1      one-cycle pulse on timeout exit
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE; inquire=0, item_idx=0, item_strobe=0, timed_out=0, counters 0.
//  req = in && en, sampled each rising edge. All outputs registered; 1-cycle latency from inputs.
//  States: IDLE, ACTIVE, LOCKOUT.
//   IDLE->ACTIVE when req=1: next cycle inquire=1, item_idx=0, item_strobe=1; both counters cleared.
//   ACTIVE->IDLE when req=0: inquire=0, item_idx=0; no strobe. Has priority over every other event.
//   ACTIVE->LOCKOUT when inactivity count reaches TIMEOUT-1 (TIMEOUT>0) with no next/prev that cycle:
//     inquire=0, item_idx=0, timed_out=1 for one cycle.
//   LOCKOUT->IDLE when req=0. No re-entry until req has been seen low for >=1 cycle.
//   LOCKOUT with req=1: stays; outputs idle.
//  Index moves in ACTIVE (req=1):
//   next_p only: idx+1, NUM_ITEMS-1 wraps to 0. prev_p only: idx-1, 0 wraps to NUM_ITEMS-1.
//   next_p & prev_p same cycle: no move, no strobe; counts as activity.
//   Any move: item_strobe=1 next cycle.
//  Inactivity counter: cleared on entry and on any next_p/prev_p; increments otherwise in ACTIVE;
//   auto-scan steps do not clear it. A press in the expiry cycle cancels the timeout.
//  Auto-scan (AUTO_SCAN=1): dwell counter increments in ACTIVE; at DWELL-1, idx+1 (with wrap),
//   strobe, counter cleared. A manual press clears the dwell counter; the manual move wins.
//   If the timeout fires in the same cycle as the dwell expiry, the timeout wins.
//  next_p/prev_p ignored outside ACTIVE. Reset mid-ACTIVE: immediate return to reset values.
//  Counter widths: $clog2(TIMEOUT+1) and $clog2(DWELL+1) bits, minimum 1; counters saturate, never wrap.
// STRUCTURE
//  Package inquire_pkg: state enum (IDLE, ACTIVE, LOCKOUT), function idx_w(n) = max(1,$clog2(n)).
//  Sub-module inquire_cnt (parameter LIMIT; inputs clr and inc; output hit at LIMIT-1, saturating).
//   Instantiated twice: inactivity counter and dwell counter. Dwell instance is generate-gated on AUTO_SCAN.
//  FSM and index register live in inquire_scan.
// TESTING  (NUM_ITEMS=4, TIMEOUT=10, DWELL=3 unless noted)
//  1 rst_n low mid-ACTIVE at idx=2 -> all outputs 0 asynchronously; after release, req=1 gives idx=0, strobe.
//  2 req=1, three next_p then two prev_p -> idx 0,1,2,3,2,1, each move with a 1-cycle strobe;
//    from idx=3, next_p -> 0; from idx=0, prev_p -> 3.
//  3 next_p & prev_p same cycle at idx=1 -> idx stays 1, no strobe, inactivity counter cleared.
//  4 req=1 held with no presses -> 10 cycles after entry timed_out=1 pulse, inquire=0, LOCKOUT held;
//    req low 1 cycle, then high -> re-entry at idx=0.
//  5 AUTO_SCAN=1, TIMEOUT=0 -> idx advances every 3 cycles 0,1,2,3,0; next_p at dwell cycle 2 moves once
//    and the dwell restarts.
//  6 en dropped in the same cycle as next_p -> inquire=0, idx=0, no strobe.

Source files
------------

// File: rtl/inquire_pkg.sv
// inquire_pkg: shared state encoding and width helper for the query-mode controller
package inquire_pkg;
    typedef enum logic [1:0] {IDLE, ACTIVE, LOCKOUT} state_t;

    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/inquire_cnt.sv
// inquire_cnt: saturating event counter flagging hit at LIMIT-1; LIMIT=0 never hits
module inquire_cnt
    import inquire_pkg::*;
#(
    parameter int LIMIT = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic hit
);
    localparam int W = idx_w(LIMIT + 1);
    localparam logic [W-1:0] TOP = W'(LIMIT == 0 ? 0 : LIMIT - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (inc && cnt != TOP) cnt <= cnt + 1'b1;
    end

    assign hit = (LIMIT != 0) && (cnt == TOP);
endmodule

// File: rtl/inquire_scan.sv
// inquire_scan: query-mode FSM stepping an item index via next/prev pulses, auto-scan and inactivity timeout
module inquire_scan
    import inquire_pkg::*;
#(
    parameter int NUM_ITEMS = 8,
    parameter int TIMEOUT   = 1000,
    parameter int AUTO_SCAN = 0,
    parameter int DWELL     = 100,
    localparam int IDX_W    = idx_w(NUM_ITEMS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in,
    input  logic             en,
    input  logic             next_p,
    input  logic             prev_p,
    output logic             inquire,
    output logic [IDX_W-1:0] item_idx,
    output logic             item_strobe,
    output logic             timed_out
);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_ITEMS - 1);

    state_t state, state_n;
    logic [IDX_W-1:0] idx_n, idx_up, idx_dn;
    logic req, press, act, inact_hit, dwell_hit, strobe_n, to_n;

    assign req    = in && en;
    assign press  = next_p || prev_p;
    assign act    = (state == ACTIVE) && req;
    assign idx_up = (item_idx == LAST) ? '0 : item_idx + 1'b1;
    assign idx_dn = (item_idx == '0) ? LAST : item_idx - 1'b1;

    inquire_cnt #(.LIMIT(TIMEOUT)) u_inact (
        .clk(clk), .rst_n(rst_n), .clr(!act || press), .inc(act), .hit(inact_hit)
    );

    // auto-scan steps restart the dwell but leave the inactivity count running
    if (AUTO_SCAN != 0) begin : g_dwell
        inquire_cnt #(.LIMIT(DWELL)) u_dwell (
            .clk(clk), .rst_n(rst_n), .clr(!act || press || dwell_hit), .inc(act), .hit(dwell_hit)
        );
    end else begin : g_nodwell
        assign dwell_hit = 1'b0;
    end

    always_comb begin
        state_n  = state;
        idx_n    = item_idx;
        strobe_n = 1'b0;
        to_n     = 1'b0;
        case (state)
            IDLE: if (req) begin
                state_n  = ACTIVE;
                idx_n    = '0;
                strobe_n = 1'b1;
            end
            ACTIVE: if (!req) begin
                state_n = IDLE;
                idx_n   = '0;
            end else if (inact_hit && !press) begin
                state_n = LOCKOUT;
                idx_n   = '0;
                to_n    = 1'b1;
            end else if (next_p != prev_p) begin
                idx_n    = next_p ? idx_up : idx_dn;
                strobe_n = 1'b1;
            end else if (!press && dwell_hit) begin
                idx_n    = idx_up;
                strobe_n = 1'b1;
            end
            LOCKOUT: if (!req) state_n = IDLE;
            default: begin
                state_n = IDLE;
                idx_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            item_idx    <= '0;
            item_strobe <= 1'b0;
            timed_out   <= 1'b0;
        end else begin
            state       <= state_n;
            item_idx    <= idx_n;
            item_strobe <= strobe_n;
            timed_out   <= to_n;
        end
    end

    assign inquire = (state == ACTIVE);
endmodule

// File: tb/tb_inquire_scan.sv
// tb_inquire_scan: directed plus random stimulus on a manual/timeout instance and an auto-scan instance
module tb_inquire_scan;
    localparam int N = 4;
    localparam int D = 3;

    logic clk = 1'b0, rst_n = 1'b0;
    logic in = 1'b0, en = 1'b0, next_p = 1'b0, prev_p = 1'b0;
    logic q0, s0, t0, q1, s1, t1;
    logic [1:0] i0, i1;

    int evals = 0, fails = 0;
    int md[2], ix[2], qt[2], sn[2];
    bit st[2], to[2];

    always #5 clk = ~clk;

    inquire_scan #(.NUM_ITEMS(N), .TIMEOUT(10), .AUTO_SCAN(0), .DWELL(D)) dut0 (
        .clk(clk), .rst_n(rst_n), .in(in), .en(en), .next_p(next_p), .prev_p(prev_p),
        .inquire(q0), .item_idx(i0), .item_strobe(s0), .timed_out(t0)
    );
    inquire_scan #(.NUM_ITEMS(N), .TIMEOUT(0), .AUTO_SCAN(1), .DWELL(D)) dut1 (
        .clk(clk), .rst_n(rst_n), .in(in), .en(en), .next_p(next_p), .prev_p(prev_p),
        .inquire(q1), .item_idx(i1), .item_strobe(s1), .timed_out(t1)
    );

    // mode 0 idle, 1 active, 2 locked out; qt = cycles since activity, sn = cycles since last index step
    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            md[m] = 0; ix[m] = 0; qt[m] = 0; sn[m] = 0; st[m] = 0; to[m] = 0;
        end
    endtask

    task automatic model(input bit req, input bit n, input bit p);
        for (int m = 0; m < 2; m++) begin
            int t;
            t = (m == 0) ? 10 : 0;
            st[m] = 0; to[m] = 0;
            if (md[m] == 0) begin
                if (req) begin md[m] = 1; ix[m] = 0; st[m] = 1; qt[m] = 0; sn[m] = 0; end
            end else if (md[m] == 1) begin
                if (!req) begin
                    md[m] = 0; ix[m] = 0;
                end else if (n || p) begin
                    qt[m] = 0; sn[m] = 0;
                    if (n && !p) begin ix[m] = (ix[m] + 1) % N; st[m] = 1; end
                    if (p && !n) begin ix[m] = (ix[m] + N - 1) % N; st[m] = 1; end
                end else begin
                    qt[m]++;
                    if (t > 0 && qt[m] == t) begin
                        md[m] = 2; ix[m] = 0; to[m] = 1;
                    end else begin
                        sn[m]++;
                        if (m == 1 && sn[m] == D) begin sn[m] = 0; ix[m] = (ix[m] + 1) % N; st[m] = 1; end
                    end
                end
            end else if (!req) md[m] = 0;
        end
    endtask

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        evals++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("inquire0", {1'b0, q0}, {1'b0, md[0] == 1});
        chk("idx0", i0, 2'(ix[0]));
        chk("strobe0", {1'b0, s0}, {1'b0, st[0]});
        chk("timed_out0", {1'b0, t0}, {1'b0, to[0]});
        chk("inquire1", {1'b0, q1}, {1'b0, md[1] == 1});
        chk("idx1", i1, 2'(ix[1]));
        chk("strobe1", {1'b0, s1}, {1'b0, st[1]});
        chk("timed_out1", {1'b0, t1}, {1'b0, to[1]});
    endtask

    task automatic cyc(input bit i, input bit e, input bit n, input bit p);
        in = i; en = e; next_p = n; prev_p = p;
        @(posedge clk);
        model(i && e, n, p);
        @(negedge clk);
        check_all();
        next_p = 1'b0; prev_p = 1'b0;
    endtask

    initial begin
        model_reset();
        @(negedge clk); @(negedge clk);
        check_all();
        rst_n = 1'b1;
        // async reset mid-ACTIVE at idx 2
        cyc(1, 1, 0, 0); cyc(1, 1, 1, 0); cyc(1, 1, 1, 0);
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        // entry, stepping and wrap in both directions
        cyc(1, 1, 0, 0);
        repeat (3) cyc(1, 1, 1, 0);
        repeat (2) cyc(1, 1, 0, 1);
        repeat (3) cyc(1, 1, 1, 0);
        cyc(1, 1, 0, 1);
        cyc(1, 1, 1, 0); cyc(1, 1, 1, 0);
        // simultaneous press, then run into timeout and lockout
        cyc(1, 1, 1, 1);
        repeat (13) cyc(1, 1, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(1, 1, 0, 0);
        // press landing on the dwell expiry cycle
        repeat (2) cyc(1, 1, 0, 0);
        cyc(1, 1, 1, 0);
        repeat (7) cyc(1, 1, 0, 0);
        // enable dropped together with next_p
        cyc(1, 0, 1, 0);
        cyc(1, 1, 0, 0);
        // press in the expiry cycle cancels the timeout
        repeat (9) cyc(1, 1, 0, 0);
        cyc(1, 1, 0, 1);
        repeat (11) cyc(1, 1, 0, 0);
        cyc(0, 0, 0, 0);
        repeat (400)
            cyc($urandom_range(7) != 0, $urandom_range(15) != 0,
                $urandom_range(5) == 0, $urandom_range(5) == 0);
        $display("End of test - %0d assertions evaluated, %0d failures", evals, fails);
        $finish;
    end
endmodule
